// File: rtl/playbus_sequencer_if.sv
// PlayBus sequencer bus interface.
// Groups the control, program-ROM and controller-facing signals of playbus_sequencer.
//   master : sequencer side (drives pc, func, func_valid, ram_addr, busy, halted)
//   slave  : environment side (drives run, step, clear, instr)
// Optional macro SEQ_BREAKPOINT_EN adds bp_addr/bp_en (to sequencer) and bp_hit (from it).
interface playbus_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OPND_W = 4
);
  logic              run;
  logic              step;
  logic              clear;
  logic [OPND_W+3:0] instr;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        func;
  logic              func_valid;
  logic [OPND_W-1:0] ram_addr;
  logic              busy;
  logic              halted;
`ifdef SEQ_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_en;
  logic              bp_hit;
`endif

  modport master (
`ifdef SEQ_BREAKPOINT_EN
    input  bp_addr, bp_en,
    output bp_hit,
`endif
    input  run, step, clear, instr,
    output pc, func, func_valid, ram_addr, busy, halted
  );

  modport slave (
`ifdef SEQ_BREAKPOINT_EN
    output bp_addr, bp_en,
    input  bp_hit,
`endif
    output run, step, clear, instr,
    input  pc, func, func_valid, ram_addr, busy, halted
  );
endinterface

// File: rtl/playbus_sequencer.sv
// PlayBus level 1 instruction sequencer.
// Holds the program counter, fetches instruction words from a combinational program ROM and
// presents the func code to the PlayBus controller: 1 cycle for func 0-2, 2 cycles for
// func 3-7 (func_valid only in the first). Supports run/step control and halt detection.
//
// Ports:
//   clk      : system clock, rising edge
//   n_reset  : synchronous active-low reset
//   bus      : playbus_sequencer_if.master
//              in : run, step, clear, instr
//              out: pc, func, func_valid, ram_addr, busy, halted
// Optional feature (macro SEQ_BREAKPOINT_EN): run-mode breakpoint on pc == bp_addr, adding
// bp_addr/bp_en inputs and a bp_hit output on the interface.
//
// Instruction word: [OPND_W+3] halt flag, [OPND_W+2:3] operand, [2:0] func.
module playbus_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OPND_W = 4
) (
  input logic                   clk,
  input logic                   n_reset,
  playbus_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StExec2,
    StHalt
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [OPND_W+3:0]   ir_q;
  logic [2:0]          func_q;
  logic                func_valid_q;
  logic                busy_q;
  logic                halted_q;
`ifdef SEQ_BREAKPOINT_EN
  logic                via_step_q;  // current FETCH was entered by a step from IDLE
  logic                bp_hit_q;
`endif

  // Outcome of completing the instruction held in ir (leaving EXEC or EXEC2).
  logic   halt_flag;
  state_e cmpl_state;

  assign halt_flag = ir_q[OPND_W+3];

  always_comb begin
    cmpl_state = StIdle;
    if (halt_flag) begin
      cmpl_state = StHalt;
    end else if (bus.run) begin
      cmpl_state = StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      func_q       <= 3'd0;
      func_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      via_step_q   <= 1'b0;
      bp_hit_q     <= 1'b0;
`endif
    end else if (bus.clear) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      func_q       <= 3'd0;
      func_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      via_step_q   <= 1'b0;
      bp_hit_q     <= 1'b0;
`endif
    end else begin
      // func_valid is a single-cycle pulse, set only on entry to EXEC.
      func_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.run || bus.step) begin
            state_q    <= StFetch;
            busy_q     <= 1'b1;
`ifdef SEQ_BREAKPOINT_EN
            // run wins when both are high, so only a lone step bypasses breakpoints.
            via_step_q <= !bus.run;
            bp_hit_q   <= 1'b0;
`endif
          end
        end

        StFetch: begin
`ifdef SEQ_BREAKPOINT_EN
          if (bus.bp_en && (pc_q == bus.bp_addr) && !via_step_q) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            bp_hit_q <= 1'b1;
          end else begin
            ir_q         <= bus.instr;
            func_q       <= bus.instr[2:0];
            func_valid_q <= 1'b1;
            state_q      <= StExec;
          end
`else
          ir_q         <= bus.instr;
          func_q       <= bus.instr[2:0];
          func_valid_q <= 1'b1;
          state_q      <= StExec;
`endif
        end

        StExec: begin
          if (ir_q[2:0] >= 3'd3) begin
            // Long func: hold func one more cycle for the controller's xfer phase.
            state_q <= StExec2;
          end else begin
            state_q  <= cmpl_state;
            busy_q   <= (cmpl_state == StFetch);
            halted_q <= (cmpl_state == StHalt);
            func_q   <= 3'd0;
            if (!halt_flag) begin
              pc_q <= pc_q + 1'b1;
            end
`ifdef SEQ_BREAKPOINT_EN
            via_step_q <= 1'b0;
`endif
          end
        end

        StExec2: begin
          state_q  <= cmpl_state;
          busy_q   <= (cmpl_state == StFetch);
          halted_q <= (cmpl_state == StHalt);
          func_q   <= 3'd0;
          if (!halt_flag) begin
            pc_q <= pc_q + 1'b1;
          end
`ifdef SEQ_BREAKPOINT_EN
          via_step_q <= 1'b0;
`endif
        end

        StHalt: begin
          // Only clear or reset leaves HALT; both are handled above.
          state_q <= StHalt;
        end

        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
          func_q   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.func       = func_q;
  assign bus.func_valid = func_valid_q;
  assign bus.ram_addr   = ir_q[OPND_W+2:3];
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
`ifdef SEQ_BREAKPOINT_EN
  assign bus.bp_hit     = bp_hit_q;
`endif

endmodule

// File: tb/tb_playbus_sequencer.sv
// Directed self-checking bench for playbus_sequencer (ADDR_W=4, OPND_W=4).
// A 16-word program ROM array drives instr combinationally from pc.
module tb_playbus_sequencer;

  logic clk;
  logic n_reset;
  logic [7:0] rom [16];
  int n_cmp;
  int n_err;

  playbus_sequencer_if #(.ADDR_W(4), .OPND_W(4)) bus ();

  assign bus.instr = rom[bus.pc];

  playbus_sequencer #(.ADDR_W(4), .OPND_W(4)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.pc !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0h expected 0", bus.pc); end
    n_cmp++; if (bus.func !== 3'd0) begin n_err++; $display("FAIL reset_func: got %0h expected 0", bus.func); end
    n_cmp++; if (bus.func_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b expected 0", bus.func_valid); end
    n_cmp++; if (bus.ram_addr !== 4'd0) begin n_err++; $display("FAIL reset_ram_addr: got %0h expected 0", bus.ram_addr); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    n_reset = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_stays: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_run_halt;
    clear_rom();
    rom[0] = 8'h01;
    rom[1] = 8'h80;
    bus.run = 1'b1;
    tick();  // FETCH pc0
    n_cmp++; if (bus.busy !== 1'b1 || bus.func_valid !== 1'b0) begin n_err++; $display("FAIL rh_fetch0: busy/fv got %b%b expected 10", bus.busy, bus.func_valid); end
    tick();  // EXEC func1
    n_cmp++; if (bus.func_valid !== 1'b1 || bus.func !== 3'd1) begin n_err++; $display("FAIL rh_exec0: fv/func got %b/%0h expected 1/1", bus.func_valid, bus.func); end
    tick();  // FETCH pc1
    n_cmp++; if (bus.pc !== 4'd1 || bus.func_valid !== 1'b0 || bus.func !== 3'd0) begin n_err++; $display("FAIL rh_fetch1: pc/fv/func got %0h/%b/%0h expected 1/0/0", bus.pc, bus.func_valid, bus.func); end
    tick();  // EXEC func0 with halt flag
    n_cmp++; if (bus.func_valid !== 1'b1 || bus.func !== 3'd0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rh_exec1: fv/func/busy got %b/%0h/%b expected 1/0/1", bus.func_valid, bus.func, bus.busy); end
    tick();  // HALT
    n_cmp++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 4'd1) begin n_err++; $display("FAIL rh_halt: halted/busy/pc got %b/%b/%0h expected 1/0/1", bus.halted, bus.busy, bus.pc); end
    tick();
    n_cmp++; if (bus.halted !== 1'b1 || bus.func_valid !== 1'b0) begin n_err++; $display("FAIL rh_halt_hold: halted/fv got %b/%b expected 1/0", bus.halted, bus.func_valid); end
  endtask

  task automatic test_clear_and_both;
    bus.run = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_cmp++; if (bus.pc !== 4'd0 || bus.halted !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL clr_halt: pc/halted/busy got %0h/%b/%b expected 0/0/0", bus.pc, bus.halted, bus.busy); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clr_idle: busy got %b expected 0", bus.busy); end
    bus.run = 1'b1;
    bus.step = 1'b1;
    tick();  // FETCH
    bus.step = 1'b0;
    tick();  // EXEC func1
    n_cmp++; if (bus.func_valid !== 1'b1 || bus.func !== 3'd1) begin n_err++; $display("FAIL both_exec: fv/func got %b/%0h expected 1/1", bus.func_valid, bus.func); end
    tick();  // continuous: FETCH pc1
    n_cmp++; if (bus.busy !== 1'b1 || bus.pc !== 4'd1) begin n_err++; $display("FAIL both_continue: busy/pc got %b/%0h expected 1/1", bus.busy, bus.pc); end
    bus.run = 1'b0;
  endtask

  task automatic test_step;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    clear_rom();
    rom[0] = 8'h23;  // func 3, operand 4
    rom[1] = 8'h0A;  // func 2, operand 1
    bus.step = 1'b1;
    tick();  // FETCH
    bus.step = 1'b0;
    tick();  // EXEC
    n_cmp++; if (bus.func !== 3'd3 || bus.func_valid !== 1'b1 || bus.ram_addr !== 4'd4) begin n_err++; $display("FAIL step_exec: func/fv/ram got %0h/%b/%0h expected 3/1/4", bus.func, bus.func_valid, bus.ram_addr); end
    tick();  // EXEC2
    n_cmp++; if (bus.func !== 3'd3 || bus.func_valid !== 1'b0 || bus.ram_addr !== 4'd4 || bus.busy !== 1'b1) begin n_err++; $display("FAIL step_exec2: func/fv/ram/busy got %0h/%b/%0h/%b expected 3/0/4/1", bus.func, bus.func_valid, bus.ram_addr, bus.busy); end
    tick();  // IDLE
    n_cmp++; if (bus.pc !== 4'd1 || bus.busy !== 1'b0 || bus.func !== 3'd0) begin n_err++; $display("FAIL step_done: pc/busy/func got %0h/%b/%0h expected 1/0/0", bus.pc, bus.busy, bus.func); end
    tick();
    n_cmp++; if (bus.pc !== 4'd1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL step_idle_hold: pc/busy got %0h/%b expected 1/0", bus.pc, bus.busy); end
    bus.step = 1'b1;
    tick();  // FETCH pc1
    bus.step = 1'b0;
    tick();  // EXEC func2
    n_cmp++; if (bus.func !== 3'd2 || bus.func_valid !== 1'b1 || bus.ram_addr !== 4'd1) begin n_err++; $display("FAIL step2_exec: func/fv/ram got %0h/%b/%0h expected 2/1/1", bus.func, bus.func_valid, bus.ram_addr); end
    tick();  // IDLE
    n_cmp++; if (bus.pc !== 4'd2 || bus.busy !== 1'b0) begin n_err++; $display("FAIL step2_done: pc/busy got %0h/%b expected 2/0", bus.pc, bus.busy); end
  endtask

  task automatic test_wrap;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    // Word i: operand i, func i mod 8, no halt flag.
    for (int i = 0; i < 16; i++) rom[i] = 8'((i << 3) | (i & 7));
    bus.run = 1'b1;
    tick();  // FETCH pc0
    for (int k = 0; k < 18; k++) begin
      tick();  // EXEC
      n_cmp++;
      if (bus.func_valid !== 1'b1 || bus.pc !== 4'(k % 16) || bus.func !== 3'(k % 8) ||
          bus.ram_addr !== 4'(k % 16)) begin
        n_err++;
        $display("FAIL wrap_exec%0d: fv/pc/func/ram got %b/%0h/%0h/%0h expected 1/%0h/%0h/%0h",
                 k, bus.func_valid, bus.pc, bus.func, bus.ram_addr, k % 16, k % 8, k % 16);
      end
      if ((k % 8) >= 3) begin
        tick();  // EXEC2
        n_cmp++;
        if (bus.func_valid !== 1'b0 || bus.func !== 3'(k % 8)) begin
          n_err++;
          $display("FAIL wrap_exec2_%0d: fv/func got %b/%0h expected 0/%0h", k, bus.func_valid, bus.func, k % 8);
        end
      end
      tick();  // FETCH of next word
      n_cmp++;
      if (bus.func_valid !== 1'b0 || bus.busy !== 1'b1 || bus.pc !== 4'((k + 1) % 16)) begin
        n_err++;
        $display("FAIL wrap_fetch%0d: fv/busy/pc got %b/%b/%0h expected 0/1/%0h",
                 k, bus.func_valid, bus.busy, bus.pc, (k + 1) % 16);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    // Still running from test_wrap; find EXEC of the func-5 word.
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.func_valid === 1'b1 && bus.func === 3'd5) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rm_find_func5: got none expected func5 exec within 20 cycles"); end
    tick();  // EXEC2
    n_cmp++; if (bus.func !== 3'd5 || bus.func_valid !== 1'b0 || bus.pc !== 4'd5) begin n_err++; $display("FAIL rm_exec2: func/fv/pc got %0h/%b/%0h expected 5/0/5", bus.func, bus.func_valid, bus.pc); end
    n_reset = 1'b0;
    bus.run = 1'b0;
    tick();
    n_reset = 1'b1;
    n_cmp++; if (bus.pc !== 4'd0 || bus.func !== 3'd0 || bus.func_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_after: pc/func/fv/busy got %0h/%0h/%b/%b expected 0/0/0/0", bus.pc, bus.func, bus.func_valid, bus.busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.func_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_quiet%0d: fv/busy got %b/%b expected 0/0", i, bus.func_valid, bus.busy); end
    end
  endtask

`ifdef SEQ_BREAKPOINT_EN
  task automatic test_breakpoint;
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    clear_rom();
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'h03;
    bus.bp_en = 1'b1;
    bus.bp_addr = 4'd2;
    bus.run = 1'b1;
    tick();  // FETCH pc0
    tick();  // EXEC
    tick();  // FETCH pc1
    tick();  // EXEC
    n_cmp++; if (bus.func !== 3'd2 || bus.func_valid !== 1'b1 || bus.bp_hit !== 1'b0) begin n_err++; $display("FAIL bp_exec1: func/fv/bp_hit got %0h/%b/%b expected 2/1/0", bus.func, bus.func_valid, bus.bp_hit); end
    tick();  // FETCH pc2, breakpoint
    bus.run = 1'b0;
    tick();
    n_cmp++; if (bus.pc !== 4'd2 || bus.bp_hit !== 1'b1 || bus.busy !== 1'b0 || bus.func_valid !== 1'b0) begin n_err++; $display("FAIL bp_stop: pc/bp_hit/busy/fv got %0h/%b/%b/%b expected 2/1/0/0", bus.pc, bus.bp_hit, bus.busy, bus.func_valid); end
    bus.step = 1'b1;
    tick();  // FETCH via step
    bus.step = 1'b0;
    n_cmp++; if (bus.bp_hit !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL bp_step_clear: bp_hit/busy got %b/%b expected 0/1", bus.bp_hit, bus.busy); end
    tick();  // EXEC func3
    n_cmp++; if (bus.func !== 3'd3 || bus.func_valid !== 1'b1 || bus.pc !== 4'd2) begin n_err++; $display("FAIL bp_step_exec: func/fv/pc got %0h/%b/%0h expected 3/1/2", bus.func, bus.func_valid, bus.pc); end
    tick();  // EXEC2
    tick();  // IDLE
    n_cmp++; if (bus.pc !== 4'd3 || bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_step_done: pc/busy got %0h/%b expected 3/0", bus.pc, bus.busy); end
    bus.bp_en = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_reset = 1'b0;
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.clear = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bus.bp_en = 1'b0;
    bus.bp_addr = 4'd0;
`endif
    clear_rom();
    test_reset();
    test_run_halt();
    test_clear_and_both();
    test_step();
    test_wrap();
    test_reset_mid();
`ifdef SEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
